// File: rtl/cic_pkg.sv
// Shared types and constants for the CIC decimation rate controller.
package cic_pkg;

    localparam int unsigned OS_W  = 3;
    localparam int unsigned CNT_W = (1 << OS_W) - 1;

    typedef logic [OS_W-1:0]  os_sel_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam os_sel_t MAX_OS = os_sel_t'(5);
    localparam os_sel_t OS_RST = os_sel_t'(2);

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StWarmup,
        StRun
    } ctrl_state_e;

    // Decimation ratio minus one: the last value the divider counter reaches.
    function automatic cnt_t ratio_m1(input os_sel_t os);
        return cnt_t'((32'd1 << os) - 32'd1);
    endfunction

endpackage

// File: rtl/cic_rate_div.sv
// Decimation-rate divider: wraps a counter every 2**os_sel cycles, producing the
// rate strobe and the divided-clock level.
module cic_rate_div
    import cic_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    run,
    input  os_sel_t os_sel,
    output logic    dec_stb,
    output logic    dec_stb_nxt,
    output logic    div_lvl
);

    cnt_t cnt_q, cnt_d;
    logic dec_stb_q, dec_stb_d;
    logic div_lvl_q, div_lvl_d;

    always_comb begin
        cnt_d     = '0;
        dec_stb_d = 1'b0;
        div_lvl_d = 1'b0;
        if (run) begin
            dec_stb_d = (cnt_q == ratio_m1(os_sel));
            cnt_d     = dec_stb_d ? '0 : cnt_q + cnt_t'(1);
            // Upper half of the period; never true for os_sel == 0.
            div_lvl_d = (cnt_q > (ratio_m1(os_sel) >> 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            dec_stb_q <= 1'b0;
            div_lvl_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dec_stb_q <= dec_stb_d;
            div_lvl_q <= div_lvl_d;
        end
    end

    assign dec_stb     = dec_stb_q;
    assign dec_stb_nxt = dec_stb_d;
    assign div_lvl     = div_lvl_q;

endmodule

// File: rtl/cic_rate_ctrl.sv
// CIC decimator sequencing: os_sel handshake, filter clear/flush, pipeline warm-up
// and gating of output-valid onto the decimated-rate strobe.
module cic_rate_ctrl
    import cic_pkg::*;
#(
    parameter int unsigned NSTAGE    = 4,
    parameter int unsigned FLUSH_CYC = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [OS_W-1:0] os_req,
    input  logic            os_req_valid,
    output logic            os_req_ready,
    output logic [OS_W-1:0] os_sel,
    output logic            flt_clr,
    output logic            dec_stb,
    output logic            div_lvl,
    output logic            out_valid,
    output logic            busy,
    output logic            os_err
);

    localparam int unsigned FCNT_W = $clog2(FLUSH_CYC + 1);
    localparam int unsigned WCNT_W = $clog2(NSTAGE + 1);

    ctrl_state_e       state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [WCNT_W-1:0] warm_q, warm_d;
    os_sel_t           os_sel_q, os_sel_d;
    logic              os_err_q, os_err_d;
    logic              ready_q, ready_d;
    logic              flt_clr_q, flt_clr_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic accept, req_over, run, run_cur, run_nxt;
    logic stb, stb_nxt;

    always_comb begin
        accept   = os_req_valid && ready_q;
        req_over = (os_req > MAX_OS);

        state_d = state_q;
        unique case (state_q)
            StIdle:   if (enable) state_d = StFlush;
            StFlush:  if (fcnt_q == FCNT_W'(FLUSH_CYC - 1)) state_d = StWarmup;
            StWarmup: if (stb && warm_q == WCNT_W'(NSTAGE - 1)) state_d = StRun;
            StRun:    if (accept) state_d = StFlush;
            default:  state_d = StIdle;
        endcase
        if (!enable) state_d = StIdle;

        os_sel_d = os_sel_q;
        os_err_d = os_err_q;
        if (accept) begin
            os_sel_d = req_over ? MAX_OS : os_req;
            os_err_d = os_err_q | req_over;
        end

        // Counter only advances across cycles that stay in WARMUP/RUN, so every
        // (re)start begins at cnt == 0 and no strobe leaks into IDLE or FLUSH.
        run_cur = (state_q == StWarmup) || (state_q == StRun);
        run_nxt = (state_d == StWarmup) || (state_d == StRun);
        run     = run_cur && run_nxt;

        fcnt_d = '0;
        if (state_q == StFlush && state_d == StFlush) fcnt_d = fcnt_q + FCNT_W'(1);

        warm_d = '0;
        if (state_q == StWarmup && state_d == StWarmup) begin
            warm_d = stb ? warm_q + WCNT_W'(1) : warm_q;
        end

        flt_clr_d   = (state_d == StFlush);
        busy_d      = (state_d == StFlush) || (state_d == StWarmup);
        ready_d     = (state_d == StIdle) || (state_d == StRun);
        out_valid_d = (state_d == StRun) && stb_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            fcnt_q      <= '0;
            warm_q      <= '0;
            os_sel_q    <= OS_RST;
            os_err_q    <= 1'b0;
            ready_q     <= 1'b1;
            flt_clr_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            warm_q      <= warm_d;
            os_sel_q    <= os_sel_d;
            os_err_q    <= os_err_d;
            ready_q     <= ready_d;
            flt_clr_q   <= flt_clr_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    cic_rate_div u_div (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .os_sel      (os_sel_q),
        .dec_stb     (stb),
        .dec_stb_nxt (stb_nxt),
        .div_lvl     (div_lvl)
    );

    assign os_req_ready = ready_q;
    assign os_sel       = os_sel_q;
    assign flt_clr      = flt_clr_q;
    assign dec_stb      = stb;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign os_err       = os_err_q;

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Directed bench for cic_rate_ctrl: flush, warm-up, strobe period, div level,
// request clamping, enable drop and reset recovery.
module tb_cic_rate_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] os_req;
    logic       os_req_valid;
    logic       os_req_ready;
    logic [2:0] os_sel;
    logic       flt_clr;
    logic       dec_stb;
    logic       div_lvl;
    logic       out_valid;
    logic       busy;
    logic       os_err;

    int n_checks = 0;
    int n_fail   = 0;

    cic_rate_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .os_req       (os_req),
        .os_req_valid (os_req_valid),
        .os_req_ready (os_req_ready),
        .os_sel       (os_sel),
        .flt_clr      (flt_clr),
        .dec_stb      (dec_stb),
        .div_lvl      (div_lvl),
        .out_valid    (out_valid),
        .busy         (busy),
        .os_err       (os_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " os_sel"}, 32'(os_sel), 32'd2);
        check({tag, " ready"}, 32'(os_req_ready), 32'd1);
        check({tag, " flt_clr"}, 32'(flt_clr), 32'd0);
        check({tag, " dec_stb"}, 32'(dec_stb), 32'd0);
        check({tag, " div_lvl"}, 32'(div_lvl), 32'd0);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " os_err"}, 32'(os_err), 32'd0);
    endtask

    // Called just after the edge that entered FLUSH. Expects 4 clear cycles, then
    // five strobes spaced by period, only the fifth carrying out_valid.
    task automatic restart_check(input int period, input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, " flush flt_clr"}, 32'(flt_clr), 32'd1);
            check({tag, " flush ready"}, 32'(os_req_ready), 32'd0);
            check({tag, " flush busy"}, 32'(busy), 32'd1);
            tick();
        end
        check({tag, " warm flt_clr"}, 32'(flt_clr), 32'd0);
        check({tag, " warm busy"}, 32'(busy), 32'd1);
        check({tag, " warm dec_stb"}, 32'(dec_stb), 32'd0);
        for (int p = 1; p <= 5; p++) begin
            for (int j = 1; j <= period; j++) begin
                tick();
                check({tag, " div_lvl"}, 32'(div_lvl), 32'(period > 1 && j > period / 2));
                check({tag, " dec_stb"}, 32'(dec_stb), 32'(j == period));
                if (j == period) begin
                    check({tag, " out_valid"}, 32'(out_valid), 32'(p == 5));
                    check({tag, " stb ready"}, 32'(os_req_ready), 32'(p == 5));
                    check({tag, " stb busy"}, 32'(busy), 32'(p != 5));
                end
            end
        end
    endtask

    task automatic request(input logic [2:0] val);
        os_req       = val;
        os_req_valid = 1'b1;
        tick();
        os_req_valid = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        os_req       = '0;
        os_req_valid = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        reset = 1'b0;
        tick();
        check("idle ready", 32'(os_req_ready), 32'd1);
        check("idle flt_clr", 32'(flt_clr), 32'd0);

        enable = 1'b1;
        tick();
        restart_check(4, "os2");

        request(3'd3);
        check("os3 sel", 32'(os_sel), 32'd3);
        check("os3 err", 32'(os_err), 32'd0);
        restart_check(8, "os3");

        request(3'd7);
        check("os7 sel clamp", 32'(os_sel), 32'd5);
        check("os7 err", 32'(os_err), 32'd1);
        restart_check(32, "os7");

        request(3'd0);
        check("os0 sel", 32'(os_sel), 32'd0);
        restart_check(1, "os0");
        for (int i = 0; i < 4; i++) begin
            tick();
            check("os0 run dec_stb", 32'(dec_stb), 32'd1);
            check("os0 run div_lvl", 32'(div_lvl), 32'd0);
            check("os0 run out_valid", 32'(out_valid), 32'd1);
        end
        check("os_err sticky", 32'(os_err), 32'd1);

        // Drop enable mid-warm-up with a request pending.
        request(3'd2);
        for (int i = 0; i < 6; i++) tick();
        check("mid warm busy", 32'(busy), 32'd1);
        check("mid warm flt_clr", 32'(flt_clr), 32'd0);
        enable       = 1'b0;
        os_req       = 3'd1;
        os_req_valid = 1'b1;
        tick();
        check("drop busy", 32'(busy), 32'd0);
        check("drop flt_clr", 32'(flt_clr), 32'd0);
        check("drop dec_stb", 32'(dec_stb), 32'd0);
        check("drop out_valid", 32'(out_valid), 32'd0);
        check("drop ready", 32'(os_req_ready), 32'd1);
        tick();
        os_req_valid = 1'b0;
        check("idle accept sel", 32'(os_sel), 32'd1);
        check("idle accept busy", 32'(busy), 32'd0);
        enable = 1'b1;
        tick();
        restart_check(2, "os1");

        // Reset in the middle of a flush.
        request(3'd4);
        tick();
        check("pre-reset flt_clr", 32'(flt_clr), 32'd1);
        check("pre-reset sel", 32'(os_sel), 32'd4);
        reset = 1'b1;
        tick();
        check_reset_vals("mid-flush reset");
        reset = 1'b0;
        tick();
        restart_check(4, "post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
